// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants and requester ids for the register-file read arbiter.
package regfile_read_arbiter_pkg;
  localparam int REG_ID_W = 5;
  localparam int XLEN     = 32;

  typedef enum logic [0:0] {
    REQ_RS  = 1'b0,
    REQ_LSB = 1'b1
  } req_id_e;
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter; the search starts one past the last granted requester.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_valid_o
);
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] last_d;
  logic [IDW-1:0] win_id_s;
  logic [IDW-1:0] cand_s;
  logic           found_s;
  logic           hit_s;

  always_comb begin
    win_id_s = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    hit_s    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s   = (int'(last_q) + k >= N) ? IDW'(int'(last_q) + k - N) : IDW'(int'(last_q) + k);
      hit_s    = !found_s && req_i[cand_s];
      win_id_s = hit_s ? cand_s : win_id_s;
      found_s  = found_s | hit_s;
    end
  end

  always_comb begin
    gnt_valid_o = en_i & !rst_i & found_s;
    gnt_id_o    = win_id_s;
    gnt_o       = gnt_valid_o ? ({{(N-1){1'b0}}, 1'b1} << win_id_s) : '0;
    last_d      = gnt_valid_o ? win_id_s : last_q;
  end

  // Pointer resets to N-1 so requester 0 is favoured first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IDW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read port between requesters, routes responses back to
// their owner and patches reads that race a same-edge ROB commit write.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int RS_WIDTH = 2,
  parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             req_rs1_flag,
  input  logic [N_REQ-1:0]             req_rs2_flag,
  input  logic [N_REQ*REG_ID_W-1:0]    req_rs1,
  input  logic [N_REQ*REG_ID_W-1:0]    req_rs2,
  input  logic [N_REQ*RS_WIDTH-1:0]    req_index,
  output logic                         rf_rs1_flag,
  output logic                         rf_rs2_flag,
  output logic [REG_ID_W-1:0]          rf_rs1,
  output logic [REG_ID_W-1:0]          rf_rs2,
  output logic [RS_WIDTH-1:0]          rf_index,
  input  logic                         rf_rsp_rs1_flag,
  input  logic                         rf_rsp_rs2_flag,
  input  logic [RS_WIDTH-1:0]          rf_rsp_index,
  input  logic [XLEN-1:0]              rf_rsp_rs1,
  input  logic [XLEN-1:0]              rf_rsp_rs2,
  input  logic                         rob_wr_en,
  input  logic [REG_ID_W-1:0]          rob_wr_rd,
  input  logic [XLEN-1:0]              rob_wr_data,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic                         rsp_rs1_valid,
  output logic                         rsp_rs2_valid,
  output logic [RS_WIDTH-1:0]          rsp_index,
  output logic [XLEN-1:0]              rsp_rs1,
  output logic [XLEN-1:0]              rsp_rs2
);
  logic [REG_ID_W-1:0] rs1_arr_s [N_REQ];
  logic [REG_ID_W-1:0] rs2_arr_s [N_REQ];
  logic [RS_WIDTH-1:0] idx_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign rs1_arr_s[g] = req_rs1[g*REG_ID_W +: REG_ID_W];
    assign rs2_arr_s[g] = req_rs2[g*REG_ID_W +: REG_ID_W];
    assign idx_arr_s[g] = req_index[g*RS_WIDTH +: RS_WIDTH];
  end

  logic [ID_W-1:0] gnt_id_s;
  logic            gnt_valid_s;

  rr_arbiter #(.N(N_REQ), .IDW(ID_W)) u_arb (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .en_i       (rdy_in),
    .req_i      (req_valid),
    .gnt_o      (req_ready),
    .gnt_id_o   (gnt_id_s),
    .gnt_valid_o(gnt_valid_s)
  );

  logic                rf_rs1_flag_q, rf_rs1_flag_d, rf_rs2_flag_q, rf_rs2_flag_d;
  logic [REG_ID_W-1:0] rf_rs1_q, rf_rs1_d, rf_rs2_q, rf_rs2_d;
  logic [RS_WIDTH-1:0] rf_index_q, rf_index_d;
  logic [ID_W-1:0]     owner_q, owner_d, owner2_q, owner2_d;
  logic                v2_q, v2_d, byp_en_q, byp_en_d;
  logic [REG_ID_W-1:0] s2_rs1_q, s2_rs1_d, s2_rs2_q, s2_rs2_d, byp_rd_q, byp_rd_d;
  logic [XLEN-1:0]     byp_data_q, byp_data_d;
  logic                rsp_fire_s;

  always_comb begin
    rf_rs1_flag_d = rf_rs1_flag_q;
    rf_rs2_flag_d = rf_rs2_flag_q;
    rf_rs1_d      = rf_rs1_q;
    rf_rs2_d      = rf_rs2_q;
    rf_index_d    = rf_index_q;
    owner_d       = owner_q;
    if (gnt_valid_s) begin
      rf_rs1_flag_d = req_rs1_flag[gnt_id_s];
      rf_rs2_flag_d = req_rs2_flag[gnt_id_s];
      rf_rs1_d      = rs1_arr_s[gnt_id_s];
      rf_rs2_d      = rs2_arr_s[gnt_id_s];
      rf_index_d    = idx_arr_s[gnt_id_s];
      owner_d       = gnt_id_s;
    end else if (rdy_in) begin
      rf_rs1_flag_d = 1'b0;
      rf_rs2_flag_d = 1'b0;
    end else begin
      owner_d = owner_q;
    end
  end

  // v2 marks a real read in stage 2, so reads in flight across a reset are dropped.
  always_comb begin
    owner2_d   = owner2_q;
    v2_d       = v2_q;
    s2_rs1_d   = s2_rs1_q;
    s2_rs2_d   = s2_rs2_q;
    byp_en_d   = byp_en_q;
    byp_rd_d   = byp_rd_q;
    byp_data_d = byp_data_q;
    if (rdy_in) begin
      owner2_d = owner_q;
      v2_d     = rf_rs1_flag_q | rf_rs2_flag_q;
      s2_rs1_d = rf_rs1_q;
      s2_rs2_d = rf_rs2_q;
      byp_en_d = rob_wr_en & (rob_wr_rd != 5'd0);
      if (byp_en_d) begin
        byp_rd_d   = rob_wr_rd;
        byp_data_d = rob_wr_data;
      end else begin
        byp_rd_d   = byp_rd_q;
        byp_data_d = byp_data_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rf_rs1_flag_q <= 1'b0;
      rf_rs2_flag_q <= 1'b0;
      rf_rs1_q      <= '0;
      rf_rs2_q      <= '0;
      rf_index_q    <= '0;
      owner_q       <= '0;
      owner2_q      <= '0;
      v2_q          <= 1'b0;
      s2_rs1_q      <= '0;
      s2_rs2_q      <= '0;
      byp_en_q      <= 1'b0;
      byp_rd_q      <= '0;
      byp_data_q    <= '0;
    end else begin
      rf_rs1_flag_q <= rf_rs1_flag_d;
      rf_rs2_flag_q <= rf_rs2_flag_d;
      rf_rs1_q      <= rf_rs1_d;
      rf_rs2_q      <= rf_rs2_d;
      rf_index_q    <= rf_index_d;
      owner_q       <= owner_d;
      owner2_q      <= owner2_d;
      v2_q          <= v2_d;
      s2_rs1_q      <= s2_rs1_d;
      s2_rs2_q      <= s2_rs2_d;
      byp_en_q      <= byp_en_d;
      byp_rd_q      <= byp_rd_d;
      byp_data_q    <= byp_data_d;
    end
  end

  assign rf_rs1_flag = rf_rs1_flag_q;
  assign rf_rs2_flag = rf_rs2_flag_q;
  assign rf_rs1      = rf_rs1_q;
  assign rf_rs2      = rf_rs2_q;
  assign rf_index    = rf_index_q;

  // The register file returns the pre-write value when a commit lands on its sampling edge.
  always_comb begin
    rsp_fire_s    = rdy_in & !rst_in & v2_q & (rf_rsp_rs1_flag | rf_rsp_rs2_flag);
    rsp_valid     = rsp_fire_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner2_q) : '0;
    rsp_rs1_valid = rf_rsp_rs1_flag;
    rsp_rs2_valid = rf_rsp_rs2_flag;
    rsp_index     = rf_rsp_index;
    rsp_rs1       = (byp_en_q && (byp_rd_q == s2_rs1_q)) ? byp_data_q : rf_rsp_rs1;
    rsp_rs2       = (byp_en_q && (byp_rd_q == s2_rs2_q)) ? byp_data_q : rf_rsp_rs2;
  end
endmodule
